tpm_spi_frame_ctrl: RTL and testbench

TPM-over-SPI frame sequencer running in the SPI clock domain beside the SPI serializer. It decodes the 4-byte TPM SPI header, inserts TPM flow-control wait states until the transaction handler is ready, and then counts data bytes up to the requested length. It gives the transaction handler held per-frame levels: header fields, phase and status. It also gives the serializer an override for the flow-control MISO bits.

---
 rtl/tpm_spi_pkg.sv | 18 +
 rtl/sync2_ff.sv | 21 ++
 rtl/tpm_spi_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_tpm_spi_frame_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpm_spi_pkg.sv
// rtl/tpm_spi_pkg.sv - shared state encoding and header field positions for the TPM SPI frame sequencer
package tpm_spi_pkg;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    WAIT  = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } frame_state_e;

  localparam int READ_BIT = 31;
  localparam int SIZE_MSB = 29;
  localparam int SIZE_LSB = 24;
  localparam logic [7:0] TPM_ADDR_PREFIX = 8'hD4;
  localparam int HDR_BYTES = 4;

endpackage

// File: rtl/sync2_ff.sv
// rtl/sync2_ff.sv - two-flop synchronizer into the SPI clock domain with asynchronous clear
module sync2_ff (
  input  logic SPI_clock_i,
  input  logic reset_n_i,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge SPI_clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tpm_spi_frame_ctrl.sv
// rtl/tpm_spi_frame_ctrl.sv - TPM SPI header decode, flow-control wait states and data byte counting
// Optional address prefix filter: define TPM_SPI_ADDR_FILTER_EN.
module tpm_spi_frame_ctrl
  import tpm_spi_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic        SPI_clock_i,
  input  logic        reset_n_i,
  input  logic        SPI_cs_n_i,
  input  logic        SPI_mosi_i,
  input  logic        ready_i,
  output logic        flow_drive_o,
  output logic        flow_miso_o,
  output logic        hdr_valid_o,
  output logic        read_o,
  output logic [5:0]  size_o,
  output logic [23:0] addr_o,
  output logic        data_phase_o,
  output logic [5:0]  byte_idx_o,
  output logic        xfer_done_o,
  output logic        overrun_o,
  output logic        timeout_o
);

  logic              clr_n;
  frame_state_e      state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [1:0]        hdr_byte_q;
  logic [30:0]       hdr_sr_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_inc;
  logic [5:0]        byte_cnt_q;
  logic              wait_bit_q;
  logic              ready_sync;
  logic [31:0]       hdr_full;
  logic              byte_end;
  logic              last_hdr_byte;
  logic              addr_ok;

  // Chip select high clears the whole frame exactly like reset.
  assign clr_n = reset_n_i & ~SPI_cs_n_i;

  sync2_ff u_ready_sync (
    .SPI_clock_i (SPI_clock_i),
    .reset_n_i   (clr_n),
    .d           (ready_i),
    .q           (ready_sync)
  );

  assign byte_end      = (bit_cnt_q == 3'd7);
  assign last_hdr_byte = (hdr_byte_q == 2'(HDR_BYTES - 1));
  assign hdr_full      = {hdr_sr_q, SPI_mosi_i};
  assign wait_cnt_inc  = wait_cnt_q + WAIT_W'(1);
  assign byte_idx_o    = byte_cnt_q;

`ifdef TPM_SPI_ADDR_FILTER_EN
  // While header byte 3 is shifting in, address byte 1 sits at [22:15].
  assign addr_ok = (hdr_sr_q[22:15] == TPM_ADDR_PREFIX);
`else
  assign addr_ok = 1'b1;
`endif

  assign flow_miso_o = wait_bit_q && byte_end &&
                       (((state_q == HDR) && last_hdr_byte && addr_ok) || (state_q == WAIT));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR: begin
        if (byte_end && last_hdr_byte) begin
          if (!addr_ok)        state_d = ABORT;
          else if (wait_bit_q) state_d = DATA;
          else                 state_d = WAIT;
        end
      end
      WAIT: begin
        if (byte_end) begin
          if (wait_bit_q)                            state_d = DATA;
          else if (wait_cnt_inc == WAIT_W'(MAX_WAIT)) state_d = ABORT;
        end
      end
      DATA: begin
        if (byte_end && (byte_cnt_q == size_o)) state_d = DONE;
      end
      DONE:    state_d = DONE;
      ABORT:   state_d = ABORT;
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge SPI_clock_i or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= HDR;
      bit_cnt_q    <= 3'd0;
      hdr_byte_q   <= 2'd0;
      hdr_sr_q     <= '0;
      wait_cnt_q   <= '0;
      byte_cnt_q   <= 6'd0;
      wait_bit_q   <= 1'b0;
      hdr_valid_o  <= 1'b0;
      read_o       <= 1'b0;
      size_o       <= 6'd0;
      addr_o       <= 24'd0;
      data_phase_o <= 1'b0;
      xfer_done_o  <= 1'b0;
      overrun_o    <= 1'b0;
      timeout_o    <= 1'b0;
      flow_drive_o <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_q + 3'd1;

      if (state_q == HDR) begin
        hdr_sr_q <= hdr_full[30:0];
        if (byte_end) hdr_byte_q <= hdr_byte_q + 2'd1;
        if (byte_end && last_hdr_byte && addr_ok) begin
          hdr_valid_o <= 1'b1;
          read_o      <= hdr_full[READ_BIT];
          size_o      <= hdr_full[SIZE_MSB:SIZE_LSB];
          addr_o      <= hdr_full[23:0];
        end
      end

      // The flow bit for a byte is decided one bit early so it is stable for the serializer.
      if ((bit_cnt_q == 3'd6) && (((state_q == HDR) && last_hdr_byte) || (state_q == WAIT)))
        wait_bit_q <= ready_sync;

      if ((state_q == WAIT) && byte_end) wait_cnt_q <= wait_cnt_inc;
      if ((state_q == DATA) && byte_end && (byte_cnt_q != size_o))
        byte_cnt_q <= byte_cnt_q + 6'd1;
      if (state_q == DONE) overrun_o <= 1'b1;
      if ((state_q == WAIT) && (state_d == ABORT)) timeout_o <= 1'b1;

      data_phase_o <= (state_d == DATA);
      xfer_done_o  <= (state_d == DONE);
      flow_drive_o <= !((state_d == DATA) || (state_d == DONE));
    end
  end

endmodule

// File: tb/tb_tpm_spi_frame_ctrl.sv
// tb/tb_tpm_spi_frame_ctrl.sv - table-driven and randomized frame checks against a timeline reference model
module tb_tpm_spi_frame_ctrl;

  localparam int MW = 4;

  logic        SPI_clock_i = 1'b0;
  logic        reset_n_i;
  logic        SPI_cs_n_i;
  logic        SPI_mosi_i;
  logic        ready_i;
  logic        flow_drive_o;
  logic        flow_miso_o;
  logic        hdr_valid_o;
  logic        read_o;
  logic [5:0]  size_o;
  logic [23:0] addr_o;
  logic        data_phase_o;
  logic [5:0]  byte_idx_o;
  logic        xfer_done_o;
  logic        overrun_o;
  logic        timeout_o;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] hdr;
    logic [7:0]  rdy;
    logic        exp_hv;
    logic        exp_read;
    logic [5:0]  exp_size;
    logic [23:0] exp_addr;
    int          exp_done;
    int          exp_to;
  } vec_t;

  vec_t vecs[7];

  tpm_spi_frame_ctrl #(.MAX_WAIT(MW), .WAIT_W(8)) dut (
    .SPI_clock_i  (SPI_clock_i),
    .reset_n_i    (reset_n_i),
    .SPI_cs_n_i   (SPI_cs_n_i),
    .SPI_mosi_i   (SPI_mosi_i),
    .ready_i      (ready_i),
    .flow_drive_o (flow_drive_o),
    .flow_miso_o  (flow_miso_o),
    .hdr_valid_o  (hdr_valid_o),
    .read_o       (read_o),
    .size_o       (size_o),
    .addr_o       (addr_o),
    .data_phase_o (data_phase_o),
    .byte_idx_o   (byte_idx_o),
    .xfer_done_o  (xfer_done_o),
    .overrun_o    (overrun_o),
    .timeout_o    (timeout_o)
  );

  always #5 SPI_clock_i = ~SPI_clock_i;

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s [%0d]: got %0h expected %0h", name, tag, act, exp);
  endtask

  task automatic chk_idle(input int tag);
    chk("idle_hdr_valid", tag, 32'(hdr_valid_o), 32'd0);
    chk("idle_read", tag, 32'(read_o), 32'd0);
    chk("idle_size", tag, 32'(size_o), 32'd0);
    chk("idle_addr", tag, 32'(addr_o), 32'd0);
    chk("idle_data_phase", tag, 32'(data_phase_o), 32'd0);
    chk("idle_byte_idx", tag, 32'(byte_idx_o), 32'd0);
    chk("idle_xfer_done", tag, 32'(xfer_done_o), 32'd0);
    chk("idle_overrun", tag, 32'(overrun_o), 32'd0);
    chk("idle_timeout", tag, 32'(timeout_o), 32'd0);
    chk("idle_flow_miso", tag, 32'(flow_miso_o), 32'd0);
    chk("idle_flow_drive", tag, 32'(flow_drive_o), 32'd1);
  endtask

  // Drives one frame and checks every rising edge against a timeline derived from the
  // frame's wait count and length; rdy[d] is the ready level for decision d
  // (d=0 header byte 3, d>=1 wait byte d).
  task automatic run_frame(input logic [31:0] hdr, input logic [7:0] rdy, input int extra,
                           output int done_seen, output int to_seen, output logic hv,
                           output logic rd, output logic [5:0] sz, output logic [23:0] ad);
    int size, w, ds, done_e, abort_e, end_e, d, idx;
    bit ok, abrt;
    logic e_hv, e_dp, e_xd, e_ov, e_to, e_fd, e_fm;
    logic [5:0] e_idx;
    size = int'(hdr[29:24]);
    ok = 1'b1;
`ifdef TPM_SPI_ADDR_FILTER_EN
    ok = (hdr[23:16] == 8'hD4);
`endif
    w = 0;
    while (w <= MW && !rdy[w]) w++;
    abrt    = !ok || (w > MW);
    ds      = 31 + 8 * w;
    done_e  = ds + 8 + 8 * size;
    abort_e = ok ? 31 + 8 * MW : 31;
    end_e   = (abrt ? abort_e : done_e) + extra;
    done_seen = -1;
    to_seen   = -1;
    @(negedge SPI_clock_i);
    ready_i    = rdy[0];
    SPI_cs_n_i = 1'b0;
    for (int n = 0; n <= end_e; n++) begin
      SPI_mosi_i = (n < 32) ? hdr[31 - n] : 1'($urandom);
      if (n >= 32 && (n % 8) == 0 && (n - 24) / 8 <= 7) ready_i = rdy[(n - 24) / 8];
      @(posedge SPI_clock_i);
      #1;
      e_hv = ok && (n >= 31);
      if (!abrt) begin
        e_dp  = (n >= ds) && (n < done_e);
        e_xd  = (n >= done_e);
        e_ov  = (n > done_e);
        e_to  = 1'b0;
        e_fd  = (n < ds);
        idx   = (n < ds) ? 0 : (n - ds) / 8;
        e_idx = 6'((idx > size) ? size : idx);
      end else begin
        e_dp  = 1'b0;
        e_xd  = 1'b0;
        e_ov  = 1'b0;
        e_to  = ok && (n >= abort_e);
        e_fd  = 1'b1;
        e_idx = 6'd0;
      end
      e_fm = 1'b0;
      if (ok && n >= 30 && (n % 8) == 6) begin
        d = (n - 30) / 8;
        if (d <= (abrt ? MW : w)) e_fm = rdy[d];
      end
      chk("hdr_valid", n, 32'(hdr_valid_o), 32'(e_hv));
      chk("read", n, 32'(read_o), 32'(e_hv ? hdr[31] : 1'b0));
      chk("size", n, 32'(size_o), 32'(e_hv ? hdr[29:24] : 6'd0));
      chk("addr", n, 32'(addr_o), 32'(e_hv ? hdr[23:0] : 24'd0));
      chk("data_phase", n, 32'(data_phase_o), 32'(e_dp));
      chk("byte_idx", n, 32'(byte_idx_o), 32'(e_idx));
      chk("xfer_done", n, 32'(xfer_done_o), 32'(e_xd));
      chk("overrun", n, 32'(overrun_o), 32'(e_ov));
      chk("timeout", n, 32'(timeout_o), 32'(e_to));
      chk("flow_drive", n, 32'(flow_drive_o), 32'(e_fd));
      chk("flow_miso", n, 32'(flow_miso_o), 32'(e_fm));
      if (xfer_done_o === 1'b1 && done_seen < 0) done_seen = n;
      if (timeout_o === 1'b1 && to_seen < 0) to_seen = n;
      @(negedge SPI_clock_i);
    end
    hv = hdr_valid_o;
    rd = read_o;
    sz = size_o;
    ad = addr_o;
    SPI_cs_n_i = 1'b1;
    #1;
    chk_idle(end_e);
  endtask

  task automatic run_vec(input int i);
    int done_seen, to_seen;
    logic hv, rd;
    logic [5:0] sz;
    logic [23:0] ad;
    run_frame(vecs[i].hdr, vecs[i].rdy, 16, done_seen, to_seen, hv, rd, sz, ad);
    chk("tbl_hdr_valid", i, 32'(hv), 32'(vecs[i].exp_hv));
    chk("tbl_read", i, 32'(rd), 32'(vecs[i].exp_read));
    chk("tbl_size", i, 32'(sz), 32'(vecs[i].exp_size));
    chk("tbl_addr", i, 32'(ad), 32'(vecs[i].exp_addr));
    chk("tbl_done_edge", i, 32'(done_seen), 32'(vecs[i].exp_done));
    chk("tbl_timeout_edge", i, 32'(to_seen), 32'(vecs[i].exp_to));
  endtask

  initial begin
    int done_seen, to_seen;
    logic hv, rd;
    logic [5:0] sz;
    logic [23:0] ad;
    logic [31:0] hdr;

    vecs[0] = '{32'h83D40018, 8'h01, 1'b1, 1'b1, 6'd3,  24'hD40018, 63,  -1};
    vecs[1] = '{32'h01D40F00, 8'h08, 1'b1, 1'b0, 6'd1,  24'hD40F00, 71,  -1};
    vecs[2] = '{32'h80D40000, 8'h00, 1'b1, 1'b1, 6'd0,  24'hD40000, -1,  63};
    vecs[3] = '{32'h00D4AAAA, 8'hFF, 1'b1, 1'b0, 6'd0,  24'hD4AAAA, 39,  -1};
`ifdef TPM_SPI_ADDR_FILTER_EN
    vecs[4] = '{32'h80001234, 8'h01, 1'b0, 1'b0, 6'd0,  24'h000000, -1,  -1};
`else
    vecs[4] = '{32'h80001234, 8'h01, 1'b1, 1'b1, 6'd0,  24'h001234, 39,  -1};
`endif
    vecs[5] = '{32'h7FD4FFFF, 8'h02, 1'b1, 1'b0, 6'd63, 24'hD4FFFF, 551, -1};
    vecs[6] = '{32'h40D41111, 8'h10, 1'b1, 1'b0, 6'd0,  24'hD41111, 71,  -1};

    reset_n_i  = 1'b0;
    SPI_cs_n_i = 1'b0;
    SPI_mosi_i = 1'b1;
    ready_i    = 1'b1;
    repeat (3) @(negedge SPI_clock_i);
    chk_idle(0);
    reset_n_i  = 1'b1;
    SPI_cs_n_i = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Chip select dropped part way through the header, then a clean frame.
    hdr = vecs[0].hdr;
    @(negedge SPI_clock_i);
    ready_i    = 1'b1;
    SPI_cs_n_i = 1'b0;
    for (int n = 0; n <= 20; n++) begin
      SPI_mosi_i = hdr[31 - n];
      @(posedge SPI_clock_i);
      #1;
      chk("midhdr_hdr_valid", n, 32'(hdr_valid_o), 32'd0);
      chk("midhdr_flow_drive", n, 32'(flow_drive_o), 32'd1);
      @(negedge SPI_clock_i);
    end
    SPI_cs_n_i = 1'b1;
    #1;
    chk_idle(20);
    run_vec(0);

    for (int f = 0; f < 20; f++) begin
      hdr = {1'($urandom), 1'($urandom), 6'($urandom), 8'hD4, 16'($urandom)};
      run_frame(hdr, 8'($urandom_range(0, 31)), $urandom_range(0, 20),
                done_seen, to_seen, hv, rd, sz, ad);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
